// File: rtl/dcs_pkg.sv
// Shared types and default geometry for the DCSformer host driver.
package dcs_pkg;

    localparam int DCS_ROWS      = 8;
    localparam int DCS_COLS      = 16;
    localparam int DCS_OUT_W     = 32;
    localparam int DCS_JOB_BYTES = DCS_ROWS * DCS_COLS + DCS_ROWS;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SEND_I,
        ST_WAIT_WR,
        ST_SEND_W,
        ST_WAIT_O,
        ST_CAPT,
        ST_DRAIN
    } dcs_host_state_t;

endpackage

// File: rtl/dcs_result_buf.sv
// ROWS x OUT_W result capture buffer: sequential write port, registered
// valid/ready read port that starts as soon as the last word is written.
module dcs_result_buf #(
    parameter int ROWS  = 8,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [OUT_W-1:0] wr_data_i,
    output logic             wr_last_o,
    output logic             rd_valid_o,
    output logic [OUT_W-1:0] rd_data_o,
    input  logic             rd_ready_i,
    output logic             rd_done_o
);

    localparam int CNT_W = $clog2(ROWS + 1);
    localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [OUT_W-1:0] res_q [ROWS];
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic             rd_valid_q;
    logic [OUT_W-1:0] rd_data_q;
    logic             wr_ok;
    logic             rd_fire;

    // Writes beyond the last slot are dropped rather than wrapping.
    assign wr_ok     = wr_en_i && (wr_cnt_q != CNT_W'(ROWS));
    assign wr_last_o = wr_ok && (wr_cnt_q == CNT_W'(ROWS - 1));
    assign rd_fire   = rd_valid_q && rd_ready_i;
    assign rd_done_o = rd_fire && (rd_cnt_q == CNT_W'(ROWS - 1));

    // NOTE: the result array has no reset; every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            res_q[wr_cnt_q[AW-1:0]] <= wr_data_i;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (rd_done_o) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
            if (wr_last_o) begin
                rd_valid_q <= 1'b1;
                rd_cnt_q   <= '0;
                rd_data_q  <= (wr_cnt_q == '0) ? wr_data_i : res_q[0];
            end else if (rd_fire) begin
                rd_cnt_q  <= rd_cnt_q + CNT_W'(1);
                rd_data_q <= res_q[rd_cnt_q[AW-1:0] + AW'(1)];
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/dcs_host.sv
// Host-side job sequencer for the DCSformer core: load, replay, weights, capture, drain.
// Optional watchdog enabled by defining DCS_HOST_TIMEOUT_EN.
module dcs_host
    import dcs_pkg::*;
#(
    parameter int ROWS    = DCS_ROWS,
    parameter int COLS    = DCS_COLS,
    parameter int OUT_W   = DCS_OUT_W,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             i_valid,
    output logic [7:0]       i_data,
    input  logic             w_ready,
    output logic             w_valid,
    output logic [7:0]       w_data,
    input  logic             o_valid,
    input  logic [OUT_W-1:0] o_data,
    output logic             m_valid,
    output logic [OUT_W-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             err
);

    localparam int MAT_N = ROWS * COLS;
    localparam int JOB_N = MAT_N + ROWS;
    localparam int IDX_W = $clog2(JOB_N + 1);

    localparam logic [IDX_W-1:0] MAT_IDX  = IDX_W'(MAT_N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(JOB_N - 1);
    localparam logic [IDX_W-1:0] WT_IDX   = IDX_W'(ROWS);

    dcs_host_state_t  state_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       job_q [JOB_N];
    logic             s_ready_q;
    logic             busy_q;
    logic             i_valid_q;
    logic [7:0]       i_data_q;
    logic             w_valid_q;
    logic [7:0]       w_data_q;

    logic s_fire;
    logic in_capt;
    logic capt_en;
    logic wr_last;
    logic rd_done;
    logic abort;

    assign s_fire  = s_valid && s_ready_q;
    assign in_capt = (state_q == ST_WAIT_O) || (state_q == ST_CAPT);
    assign capt_en = o_valid && in_capt;

`ifdef DCS_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;
    logic            waiting;
    logic            progress;

    assign waiting  = (state_q == ST_WAIT_WR) || in_capt;
    assign progress = ((state_q == ST_WAIT_WR) && w_ready) || capt_en;
    assign abort    = waiting && !progress && (wd_q == WD_W'(TIMEOUT));

    // Counter is held at zero outside the wait states, so it restarts on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
            if (!waiting || progress || abort) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    // Job bytes are stored row-major, with the weights appended after the matrix.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            job_q[idx_q] <= s_data;
        end
    end

    // idx_q counts loaded bytes in LOAD and issued beats in SEND_I / SEND_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            i_valid_q <= 1'b0;
            i_data_q  <= '0;
            w_valid_q <= 1'b0;
            w_data_q  <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (s_fire) begin
                        if (idx_q == LAST_IDX) begin
                            state_q   <= ST_SEND_I;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b1;
                            i_valid_q <= 1'b1;
                            i_data_q  <= job_q[0];
                            idx_q     <= IDX_W'(1);
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_SEND_I: begin
                    if (idx_q == MAT_IDX) begin
                        state_q   <= ST_WAIT_WR;
                        i_valid_q <= 1'b0;
                        i_data_q  <= '0;
                        idx_q     <= '0;
                    end else begin
                        i_data_q <= job_q[idx_q];
                        idx_q    <= idx_q + IDX_W'(1);
                    end
                end
                ST_WAIT_WR: begin
                    // Weights start one cycle after the pulse; the core clears its
                    // accumulators in the pulse cycle itself.
                    if (w_ready) begin
                        state_q   <= ST_SEND_W;
                        w_valid_q <= 1'b1;
                        w_data_q  <= job_q[MAT_IDX];
                        idx_q     <= IDX_W'(1);
                    end else if (abort) begin
                        state_q   <= ST_LOAD;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                        idx_q     <= '0;
                    end
                end
                ST_SEND_W: begin
                    if (idx_q == WT_IDX) begin
                        state_q   <= ST_WAIT_O;
                        w_valid_q <= 1'b0;
                        w_data_q  <= '0;
                        idx_q     <= '0;
                    end else begin
                        w_data_q <= job_q[MAT_IDX + idx_q];
                        idx_q    <= idx_q + IDX_W'(1);
                    end
                end
                ST_WAIT_O, ST_CAPT: begin
                    if (wr_last) begin
                        state_q <= ST_DRAIN;
                    end else if (capt_en) begin
                        state_q <= ST_CAPT;
                    end else if (abort) begin
                        state_q   <= ST_LOAD;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                        idx_q     <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (rd_done) begin
                        state_q   <= ST_LOAD;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                        idx_q     <= '0;
                    end
                end
                default: begin
                    state_q   <= ST_LOAD;
                    s_ready_q <= 1'b1;
                    busy_q    <= 1'b0;
                    idx_q     <= '0;
                end
            endcase
        end
    end

    dcs_result_buf #(
        .ROWS  (ROWS),
        .OUT_W (OUT_W)
    ) u_result_buf (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (abort),
        .wr_en_i    (capt_en),
        .wr_data_i  (o_data),
        .wr_last_o  (wr_last),
        .rd_valid_o (m_valid),
        .rd_data_o  (m_data),
        .rd_ready_i (m_ready),
        .rd_done_o  (rd_done)
    );

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign i_valid = i_valid_q;
    assign i_data  = i_data_q;
    assign w_valid = w_valid_q;
    assign w_data  = w_data_q;

endmodule
